// File: rtl/corelet_ctrl.sv
// ============================================================================
// corelet_ctrl
// ----------------------------------------------------------------------------
// Instruction sequencer for one weight-stationary tile of the corelet.  Walks
// the datapath through: weights xmem->L0, kernel load into the MAC array,
// settle padding, activations xmem->L0, execute, then drains the OFIFO into
// pmem.  Emits one 34-bit instruction word per cycle.
//
// Instruction word layout (CEN/WEN active-low):
//   [33] acc      [32] CEN_pmem  [31] WEN_pmem  [30:20] A_pmem
//   [19] CEN_xmem [18] WEN_xmem  [17:7] A_xmem
//   [6] ofifo_rd  [5] ififo_wr   [4] ififo_rd   [3] l0_rd
//   [2] l0_wr     [1] execute    [0] load
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   start        one-cycle tile start pulse, dropped while busy
//   w_base       xmem base address of the col weight words
//   a_base       xmem base address of the activation words
//   p_base       pmem base address for the output rows
//   num_act      number of activation vectors T
//   acc_en       value driven on the acc bit during pmem writes
//   ofifo_valid  corelet OFIFO holds a readable row
//   inst         registered instruction word
//   busy         registered, high from the cycle after start through DONE
//   done         registered one-cycle end-of-tile pulse
// ============================================================================
module corelet_ctrl #(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int addr_bw   = 11,
    parameter int kload_pad = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] a_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic [addr_bw-1:0] num_act,
    input  logic               acc_en,
    input  logic               ofifo_valid,
    output logic [33:0]        inst,
    output logic               busy,
    output logic               done
);

    // Word driven whenever nothing is happening: both SRAMs disabled.
    localparam logic [33:0] IDLE_WORD = 34'h1800C0000;

    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP_LO    = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_AX_LO    = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // Terminal counts of the fixed-length phases.  W_L0 runs one extra
    // cycle so the last SRAM word (1-cycle read latency) lands in L0.
    localparam logic [addr_bw-1:0] WL0_LAST  = addr_bw'(col);
    localparam logic [addr_bw-1:0] LOAD_LAST = addr_bw'(col - 1);
    localparam logic [addr_bw-1:0] PAD_LAST  = addr_bw'(kload_pad - 1);
    localparam logic [addr_bw-1:0] ONE       = addr_bw'(1);

    // Reject parameter sets that would make the fixed phases degenerate.
    if (row < 1 || col < 1 || kload_pad < 1 || addr_bw < 4) begin : g_bad_params
        $error("corelet_ctrl: row, col and kload_pad must be >= 1, addr_bw >= 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_L0,
        S_W_LOAD,
        S_W_PAD,
        S_A_L0,
        S_EXEC,
        S_OUT,
        S_DONE
    } state_t;

    state_t             state,   nxt_state;
    logic [addr_bw-1:0] k,       nxt_k;
    logic [addr_bw-1:0] w_q,     nxt_w;
    logic [addr_bw-1:0] a_q,     nxt_a;
    logic [addr_bw-1:0] p_q,     nxt_p;
    logic [addr_bw-1:0] t_q,     nxt_t;
    logic               acc_q,   nxt_acc;
    logic               pmem_wr;
    logic [addr_bw-1:0] pmem_addr;
    logic [33:0]        nxt_inst;

    // Next-state logic.  Because inst is registered, the word for a cycle is
    // built here from the state/counter that will be live in that cycle.
    // In OUT the counter k is the number of pmem writes already issued, so
    // it only advances when the OFIFO actually has a row to hand over; the
    // OFIFO valid sampled at an edge decides the word for the next cycle.
    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_w     = w_q;
        nxt_a     = a_q;
        nxt_p     = p_q;
        nxt_t     = t_q;
        nxt_acc   = acc_q;
        pmem_wr   = 1'b0;
        pmem_addr = '0;
        nxt_inst  = IDLE_WORD;

        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt_state = S_W_L0;
                    nxt_k     = '0;
                    nxt_w     = w_base;
                    nxt_a     = a_base;
                    nxt_p     = p_base;
                    nxt_t     = num_act;
                    nxt_acc   = acc_en;
                end
            end
            S_W_L0: begin
                if (k == WL0_LAST) begin
                    nxt_state = S_W_LOAD;
                    nxt_k     = '0;
                end else begin
                    nxt_k = k + ONE;
                end
            end
            S_W_LOAD: begin
                if (k == LOAD_LAST) begin
                    nxt_state = S_W_PAD;
                    nxt_k     = '0;
                end else begin
                    nxt_k = k + ONE;
                end
            end
            S_W_PAD: begin
                if (k == PAD_LAST) begin
                    nxt_state = (t_q != '0) ? S_A_L0 : S_DONE;
                    nxt_k     = '0;
                end else begin
                    nxt_k = k + ONE;
                end
            end
            S_A_L0: begin
                if (k == t_q) begin
                    nxt_state = S_EXEC;
                    nxt_k     = '0;
                end else begin
                    nxt_k = k + ONE;
                end
            end
            S_EXEC: begin
                if (k == t_q - ONE) begin
                    nxt_state = S_OUT;
                    nxt_k     = '0;
                end else begin
                    nxt_k = k + ONE;
                end
            end
            S_OUT: begin
                if (k == t_q) begin
                    nxt_state = S_DONE;
                    nxt_k     = '0;
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
                nxt_k     = '0;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_k     = '0;
            end
        endcase

        // Drain one OFIFO row into pmem whenever OUT is live and a row is ready.
        if (nxt_state == S_OUT && ofifo_valid) begin
            pmem_wr   = 1'b1;
            pmem_addr = nxt_p + nxt_k;
            nxt_k     = nxt_k + ONE;
        end

        // Build the instruction word for the upcoming cycle; anything not
        // touched here keeps its IDLE value.
        case (nxt_state)
            S_W_L0: begin
                if (nxt_k < WL0_LAST) begin
                    nxt_inst[B_CEN_X]                 = 1'b0;
                    nxt_inst[B_AX_LO +: addr_bw]      = nxt_w + nxt_k;
                end
                if (nxt_k != '0) begin
                    nxt_inst[B_L0_WR] = 1'b1;
                end
            end
            S_W_LOAD: begin
                nxt_inst[B_L0_RD] = 1'b1;
                nxt_inst[B_LOAD]  = 1'b1;
            end
            S_A_L0: begin
                if (nxt_k < nxt_t) begin
                    nxt_inst[B_CEN_X]                 = 1'b0;
                    nxt_inst[B_AX_LO +: addr_bw]      = nxt_a + nxt_k;
                end
                if (nxt_k != '0) begin
                    nxt_inst[B_L0_WR] = 1'b1;
                end
            end
            S_EXEC: begin
                nxt_inst[B_L0_RD] = 1'b1;
                nxt_inst[B_EXEC]  = 1'b1;
            end
            S_OUT: begin
                if (pmem_wr) begin
                    nxt_inst[B_ACC]                   = nxt_acc;
                    nxt_inst[B_CEN_P]                 = 1'b0;
                    nxt_inst[B_WEN_P]                 = 1'b0;
                    nxt_inst[B_AP_LO +: addr_bw]      = pmem_addr;
                    nxt_inst[B_OFIFO_RD]              = 1'b1;
                end
            end
            default: begin
                nxt_inst = IDLE_WORD;
            end
        endcase
    end

    // State, counters, latched tile parameters and all outputs are registered
    // together; reset drops everything back to IDLE immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            k     <= '0;
            w_q   <= '0;
            a_q   <= '0;
            p_q   <= '0;
            t_q   <= '0;
            acc_q <= 1'b0;
            inst  <= IDLE_WORD;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt_state;
            k     <= nxt_k;
            w_q   <= nxt_w;
            a_q   <= nxt_a;
            p_q   <= nxt_p;
            t_q   <= nxt_t;
            acc_q <= nxt_acc;
            inst  <= nxt_inst;
            busy  <= (nxt_state != S_IDLE);
            done  <= (nxt_state == S_DONE);
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// ============================================================================
// tb_corelet_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for corelet_ctrl.  Each tile request pushes the expected
// xmem read addresses, pmem writes and end-of-tile timing into queues; a
// negedge monitor pops and compares whenever the instruction word shows an
// SRAM access or done pulses.  Expected timing comes from the phase lengths
// of a tile and the OFIFO valid pattern the bench itself drives.
// ============================================================================
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int ABW = 11;
    localparam int PAD = 10;
    localparam logic [33:0] IDLE_WORD = 34'h1800C0000;
    // Weight fetch (COL+1), kernel load (COL) and settle padding (PAD).
    localparam int PROLOG = (COL + 1) + COL + PAD;
    localparam int VPLEN  = 256;

    logic           clk;
    logic           reset;
    logic           start;
    logic [ABW-1:0] w_base;
    logic [ABW-1:0] a_base;
    logic [ABW-1:0] p_base;
    logic [ABW-1:0] num_act;
    logic           acc_en;
    logic           ofifo_valid;
    logic [33:0]    inst;
    logic           busy;
    logic           done;

    corelet_ctrl #(
        .row       (ROW),
        .col       (COL),
        .addr_bw   (ABW),
        .kload_pad (PAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .w_base      (w_base),
        .a_base      (a_base),
        .p_base      (p_base),
        .num_act     (num_act),
        .acc_en      (acc_en),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [ABW-1:0] addr;
        logic           acc;
    } pwr_t;

    typedef struct {
        int lat;
        int t;
    } tile_t;

    logic [ABW-1:0] xq[$];
    pwr_t           pq[$];
    tile_t          dq[$];

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   startCyc  = 0;
    int   loadCnt   = 0;
    int   execCnt   = 0;
    int   doneCnt   = 0;
    logic validPrev = 1'b0;
    logic prevRead  = 1'b0;
    bit   monActive = 1'b0;
    bit   seqv [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Edge bookkeeping: cycle count and the OFIFO valid the DUT sampled.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        validPrev <= ofifo_valid;
    end

    // Monitor: consume expected events whenever the word shows them.
    always @(negedge clk) begin
        if (monActive) begin
            checkOutput("xmem_wen_high", inst[18], 1'b1);
            checkOutput("ififo_bits_zero", inst[5:4], 2'b00);
            checkOutput("l0_rd_with_load_or_exec", inst[3], inst[0] | inst[1]);
            checkOutput("l0_wr_lags_read", inst[2], prevRead);
            prevRead = ~inst[19];

            if (inst[19] == 1'b0) begin
                if (xq.size() == 0) begin
                    checkOutput("xmem_read_expected", 64'(xq.size()), 1);
                end else begin
                    logic [ABW-1:0] ea;
                    ea = xq.pop_front();
                    checkOutput("xmem_addr", inst[17:7], ea);
                end
            end else begin
                checkOutput("xmem_addr_idle", inst[17:7], 11'd0);
            end

            if (inst[32] == 1'b0) begin
                checkOutput("pmem_wen_low", inst[31], 1'b0);
                checkOutput("ofifo_rd_on_write", inst[6], 1'b1);
                checkOutput("ofifo_valid_at_read", validPrev, 1'b1);
                if (pq.size() == 0) begin
                    checkOutput("pmem_write_expected", 64'(pq.size()), 1);
                end else begin
                    pwr_t ew;
                    ew = pq.pop_front();
                    checkOutput("pmem_addr", inst[30:20], ew.addr);
                    checkOutput("pmem_acc", inst[33], ew.acc);
                end
            end else begin
                checkOutput("pmem_idle_fields", {inst[33], inst[31:20], inst[6]},
                            {1'b0, 1'b1, 11'd0, 1'b0});
            end

            loadCnt += int'(inst[0]);
            execCnt += int'(inst[1]);

            if (done) begin
                if (dq.size() == 0) begin
                    checkOutput("done_expected", 64'(dq.size()), 1);
                end else begin
                    tile_t et;
                    et = dq.pop_front();
                    checkOutput("done_latency", cyc - startCyc, et.lat);
                    checkOutput("load_cycles", loadCnt, COL);
                    checkOutput("exec_cycles", execCnt, et.t);
                    checkOutput("busy_in_done", busy, 1'b1);
                    checkOutput("done_word_idle", inst, IDLE_WORD);
                    checkOutput("xmem_reads_left", xq.size(), 0);
                    checkOutput("pmem_writes_left", pq.size(), 0);
                end
                loadCnt = 0;
                execCnt = 0;
                doneCnt++;
            end
        end
    end

    // Runs one tile.  Called at a negedge; returns at the negedge after the
    // cycle that follows DONE, so the next call lands its start right there.
    // mode: 0 = OFIFO always valid, 1 = fixed toggle pattern, 2 = random.
    task automatic applyStimulus(input logic [ABW-1:0] w, input logic [ABW-1:0] a,
                                 input logic [ABW-1:0] p, input logic [ABW-1:0] t,
                                 input logic acc, input int mode,
                                 input bit dropStarts, input int abortAt);
        logic vp [0:VPLEN-1];
        int   outStart;
        int   lastWr;
        int   wr;
        int   lat;
        int   doneBefore;
        logic [ABW-1:0] tmp;

        // The OUT phase begins after activation fetch (T+1) and execute (T).
        outStart = PROLOG + (int'(t) + 1) + int'(t);
        for (int i = 0; i < VPLEN; i++) begin
            if (mode == 0)      vp[i] = 1'b1;
            else if (mode == 1) vp[i] = (i >= outStart + 7);
            else                vp[i] = ($urandom_range(99) < 55) || (i >= outStart + 40);
        end
        if (mode == 1) begin
            for (int i = 0; i < 7; i++) vp[outStart + i] = seqv[i];
        end

        wr     = 0;
        lastWr = outStart;
        for (int e = outStart; e < VPLEN && wr < int'(t); e++) begin
            if (vp[e]) begin
                wr++;
                lastWr = e;
            end
        end
        lat = (t == '0) ? PROLOG + 1 : lastWr + 2;

        for (int i = 0; i < COL; i++) begin
            tmp = w + ABW'(i);
            xq.push_back(tmp);
        end
        for (int i = 0; i < int'(t); i++) begin
            pwr_t pw;
            tmp = a + ABW'(i);
            xq.push_back(tmp);
            pw.addr = p + ABW'(i);
            pw.acc  = acc;
            pq.push_back(pw);
        end
        begin
            tile_t tt;
            tt.lat = lat;
            tt.t   = int'(t);
            dq.push_back(tt);
        end
        doneBefore = doneCnt;

        w_base      = w;
        a_base      = a;
        p_base      = p;
        num_act     = t;
        acc_en      = acc;
        start       = 1'b1;
        ofifo_valid = vp[0];
        startCyc    = cyc;

        for (int e = 1; e <= lat; e++) begin
            @(negedge clk);
            if (e == 1) begin
                checkOutput("busy_after_start", busy, 1'b1);
                w_base  = ABW'($urandom_range(2047));
                a_base  = ABW'($urandom_range(2047));
                p_base  = ABW'($urandom_range(2047));
                num_act = ABW'($urandom_range(2047));
                acc_en  = ~acc;
            end
            if (e == abortAt) begin
                checkOutput("mid_exec_before_reset", inst[1], 1'b1);
                monActive = 1'b0;
                start     = 1'b0;
                #2 reset  = 1'b0;
                #1;
                checkOutput("reset_inst_async", inst, IDLE_WORD);
                checkOutput("reset_busy_async", busy, 1'b0);
                checkOutput("reset_done_async", done, 1'b0);
                xq.delete();
                pq.delete();
                dq.delete();
                loadCnt     = 0;
                execCnt     = 0;
                prevRead    = 1'b0;
                ofifo_valid = 1'b0;
                @(negedge clk);
                @(negedge clk);
                checkOutput("reset_held_inst", inst, IDLE_WORD);
                reset     = 1'b1;
                monActive = 1'b1;
                return;
            end
            start       = dropStarts && (e == 12 || e == lat);
            ofifo_valid = vp[e];
        end

        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_done", busy, 1'b0);
        checkOutput("done_one_cycle", done, 1'b0);
        checkOutput("idle_word_after_tile", inst, IDLE_WORD);
        checkOutput("tile_done_count", doneCnt, doneBefore + 1);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        w_base      = '0;
        a_base      = '0;
        p_base      = '0;
        num_act     = '0;
        acc_en      = 1'b0;
        ofifo_valid = 1'b0;

        #12;
        checkOutput("reset_inst", inst, IDLE_WORD);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        monActive = 1'b1;
        @(negedge clk);

        // Abort mid-execute, then a full tile right after.
        applyStimulus(11'd5, 11'd100, 11'd200, 11'd4, 1'b0, 0, 1'b0, 35);
        applyStimulus(11'd0, 11'd8, 11'd0, 11'd4, 1'b0, 0, 1'b0, 0);
        // Stalling OFIFO.
        applyStimulus(11'd0, 11'd8, 11'd0, 11'd4, 1'b0, 1, 1'b0, 0);
        // Address wrap on both SRAMs.
        applyStimulus(11'd100, 11'd2046, 11'd2047, 11'd4, 1'b1, 0, 1'b0, 0);
        // Empty activation set.
        applyStimulus(11'd30, 11'd40, 11'd50, 11'd0, 1'b1, 0, 1'b0, 0);
        // Starts during W_LOAD and DONE are dropped; acc only on writes.
        applyStimulus(11'd7, 11'd9, 11'd11, 11'd3, 1'b1, 0, 1'b1, 0);

        for (int n = 0; n < 12; n++) begin
            applyStimulus(ABW'($urandom_range(2047)), ABW'($urandom_range(2047)),
                          ABW'($urandom_range(2047)), ABW'($urandom_range(8)),
                          1'($urandom_range(1)), ($urandom_range(1) == 0) ? 0 : 2,
                          1'($urandom_range(1)), 0);
        end

        repeat (4) @(negedge clk);
        checkOutput("final_busy", busy, 1'b0);
        checkOutput("final_xmem_queue", xq.size(), 0);
        checkOutput("final_pmem_queue", pq.size(), 0);
        checkOutput("final_done_queue", dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
- Instruction sequencer that generates the 34-bit instruction word consumed by the corelet datapath for one weight-stationary tile.
- Drives the full flow:
  1. xmem weights into L0.
  2. Kernel load into the MAC array.
  3. xmem activations into L0.
  4. Execute.
  5. Drain the OFIFO into pmem.
- Sits between the top-level testbench/host and the corelet plus its xmem/pmem SRAMs. Reports busy/done to the host.

Parameters:
- row, 8, MAC array rows (L0 depth per word).
- col, 8, MAC array columns; number of kernel rows loaded.
- addr_bw, 11, xmem/pmem address width (matches inst fields).
- kload_pad, 10, idle cycles after kernel load so weights settle in the array.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; ignored while busy=1.
- w_base  input  addr_bw  xmem base address of the col weight words.
- a_base  input  addr_bw  xmem base address of the activation words.
- p_base  input  addr_bw  pmem base address for outputs.
- num_act  input  addr_bw  number of activation vectors T.
- acc_en  input  1  sets inst[33] (acc) on pmem writes.
- ofifo_valid  input  1  corelet OFIFO has a readable row.
- inst  output  34  instruction word.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at end of tile.

Behaviour:
- Instruction field map:
  - [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem.
  - [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem.
  - [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
  - CEN and WEN are active-low.
- IDLE word = 34'h1800C0000: both CEN=1, both WEN=1, addresses 0, all other bits 0. Unused bits in every state keep their IDLE value. ififo_wr and ififo_rd are always 0.
- inst, busy and done are all registered; inst changes only on clk rising edge.
- Reset (asynchronous, any state, including mid-tile): state=IDLE, inst=IDLE word, busy=0, done=0, counters=0.
- At start in IDLE, latch w_base, a_base, p_base, num_act (T) and acc_en. Later input changes have no effect until the next tile.
- States and counters (k resets to 0 on each state entry):
  - IDLE: wait for start, then go to W_L0.
  - W_L0, col+1 cycles, k=0..col:
    - For k<col: CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+k.
    - For k>=1: l0_wr=1 (1-cycle SRAM read latency).
    - Then go to W_LOAD.
  - W_LOAD, col cycles: l0_rd=1, load=1. Then go to W_PAD.
  - W_PAD, kload_pad cycles: IDLE word. Then go to A_L0 if T>0, else DONE.
  - A_L0, T+1 cycles:
    - For k<T: CEN_xmem=0, A_xmem=a_base+k.
    - For k>=1: l0_wr=1.
    - Then go to EXEC.
  - EXEC, T cycles: l0_rd=1, execute=1. Then go to OUT.
  - OUT, runs until T words are written:
    - When ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+k, acc=acc_en; k increments.
    - When ofifo_valid=0: IDLE word, k holds (stall, no timeout).
    - Go to DONE after the T-th write.
  - DONE, 1 cycle: IDLE word, done=1. Then go to IDLE; busy=0 from that cycle.
- Address arithmetic is modulo 2^addr_bw, so base+k wraps silently.
- start in DONE or any busy state is dropped. A start in the cycle after DONE is accepted.
- T=0: W_L0, W_LOAD and W_PAD execute, then DONE. No xmem activation read and no pmem write.

Test Plan:
- Reset mid-EXEC: assert reset low → inst=34'h1800C0000, busy=0 asynchronously. After release, a start runs a full tile correctly.
- w_base=0, a_base=8, p_base=0, T=4, ofifo_valid=1 throughout:
  - xmem reads at addresses 0..7, then 8..11.
  - l0_wr lags each read by 1 cycle.
  - Exactly 8 load cycles and 4 execute cycles.
  - pmem writes at addresses 0..3.
  - done occurs 8+1+8+10+5+4+4+1 cycles after start.
- Same tile, ofifo_valid toggling 1,0,0,1,1,0,1: exactly 4 pmem writes with consecutive A_pmem; no ofifo_rd while ofifo_valid=0.
- a_base=2046, T=4: A_xmem sequence 2046, 2047, 0, 1. p_base=2047: A_pmem sequence 2047, 0, 1, 2.
- T=0: no execute and no CEN_pmem=0 ever; done 28 cycles after start.
- start pulsed during W_LOAD and in DONE: ignored, only one done pulse. acc_en=1 → inst[33]=1 only on pmem-write cycles.
